// File: rtl/uart_rx_deframer_if.sv
// Byte stream handshake out of the UART receiver: head byte plus valid/ready.
// master drives rx_data/rx_valid and samples rx_ready; slave is the consumer.
interface uart_rx_deframer_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;

   modport master (
      output rx_data,
      output rx_valid,
      input  rx_ready
   );

   modport slave (
      input  rx_data,
      input  rx_valid,
      output rx_ready
   );
endinterface

// File: rtl/uart_rx_deframer.sv
// UART 8-N-1 / 8-E/O-1 receiver with a small byte FIFO on a valid/ready port.
// Ports: clk, rst_n, rxd (async line), rx_if (data/valid/ready), frame_err,
// parity_err, overrun (1-cycle pulses), busy (not idle).
module uart_rx_deframer #(
   parameter int CLKS_PER_BIT    = 667,
   parameter int PARITY          = 0,
   parameter int FIFO_DEPTH_LOG2 = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               rxd,
   uart_rx_deframer_if.master rx_if,
   output logic               frame_err,
   output logic               parity_err,
   output logic               overrun,
   output logic               busy
);
   localparam int AW    = FIFO_DEPTH_LOG2;
   localparam int PW    = AW + 1;
   localparam int DEPTH = 1 << AW;
   localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PAR,
      S_STOP,
      S_BREAK
   } state_e;

   logic [1:0]  sync_q;
   logic        rxs;
   state_e      state_q;
   logic [15:0] cnt_q;
   logic [2:0]  bit_q;
   logic [7:0]  shift_q;
   logic        pfail_q;
   logic        busy_q;
   logic        frame_err_q;
   logic        parity_err_q;
   logic        overrun_q;

   logic [7:0]  mem_q [DEPTH];
   logic [AW:0] wptr_q, rptr_q;
   logic [AW:0] wptr_d, rptr_d;
   logic [7:0]  data_q, head_d;
   logic        valid_q;

   logic bit_end, push, pop, full, push_ok;

   assign rxs     = sync_q[1];
   assign bit_end = (cnt_q == LAST);
   assign push    = (state_q == S_STOP) && bit_end && rxs && !pfail_q;
   assign pop     = valid_q && rx_if.rx_ready;
   assign full    = ((wptr_q - rptr_q) == PW'(DEPTH));
   // A pop in the same cycle frees the slot the full push lands in.
   assign push_ok = push && (!full || pop);
   assign wptr_d  = wptr_q + PW'(push_ok);
   assign rptr_d  = rptr_q + PW'(pop);

   // Next head: the byte being written bypasses the array when it
   // lands exactly where the read pointer will point.
   always_comb begin
      head_d = mem_q[rptr_d[AW-1:0]];
      if (push_ok && (rptr_d[AW-1:0] == wptr_q[AW-1:0]))
         head_d = shift_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         sync_q <= 2'b11;
      else
         sync_q <= {sync_q[0], rxd};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         bit_q        <= '0;
         shift_q      <= '0;
         pfail_q      <= 1'b0;
         busy_q       <= 1'b0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
         cnt_q        <= bit_end ? '0 : cnt_q + 16'd1;
         unique case (state_q)
            S_IDLE: begin
               cnt_q <= '0;
               if (!rxs) begin
                  state_q <= S_START;
                  busy_q  <= 1'b1;
                  pfail_q <= 1'b0;
               end
            end
            S_START: begin
               if (cnt_q == HALF) begin
                  cnt_q <= '0;
                  if (rxs) begin
                     state_q <= S_IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= S_DATA;
                     bit_q   <= '0;
                  end
               end
            end
            S_DATA: begin
               if (bit_end) begin
                  shift_q <= {rxs, shift_q[7:1]};
                  bit_q   <= bit_q + 3'd1;
                  if (bit_q == 3'd7)
                     state_q <= (PARITY != 0) ? S_PAR : S_STOP;
               end
            end
            S_PAR: begin
               if (bit_end) begin
                  pfail_q <= rxs != ((PARITY == 2) ? ~^shift_q : ^shift_q);
                  state_q <= S_STOP;
               end
            end
            S_STOP: begin
               if (bit_end) begin
                  if (rxs) begin
                     parity_err_q <= pfail_q;
                     state_q      <= S_IDLE;
                     busy_q       <= 1'b0;
                  end else begin
                     frame_err_q <= 1'b1;
                     state_q     <= S_BREAK;
                  end
               end
            end
            S_BREAK: begin
               cnt_q <= '0;
               if (rxs) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok)
         mem_q[wptr_q[AW-1:0]] <= shift_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q    <= '0;
         rptr_q    <= '0;
         valid_q   <= 1'b0;
         data_q    <= '0;
         overrun_q <= 1'b0;
      end else begin
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         overrun_q <= push && !push_ok;
         valid_q   <= (wptr_d != rptr_d);
         if (wptr_d != rptr_d)
            data_q <= head_d;
      end
   end

   assign rx_if.rx_data  = data_q;
   assign rx_if.rx_valid = valid_q;
   assign frame_err      = frame_err_q;
   assign parity_err     = parity_err_q;
   assign overrun        = overrun_q;
   assign busy           = busy_q;
endmodule

// File: tb/tb_uart_rx_deframer.sv
// Bench for uart_rx_deframer: one no-parity and one even-parity instance.
// Frames are driven bit-serially; accepted bytes are scoreboarded.
module tb_uart_rx_deframer;
   localparam int CPB = 8;

   logic clk;
   logic rst_n;
   logic rxd0, rxd1;
   logic fe0_w, pe0_w, ov0_w, busy0;
   logic fe1_w, pe1_w, ov1_w, busy1;

   uart_rx_deframer_if if0 ();
   uart_rx_deframer_if if1 ();

   uart_rx_deframer #(
      .CLKS_PER_BIT(CPB), .PARITY(0), .FIFO_DEPTH_LOG2(2)
   ) u0 (
      .clk(clk), .rst_n(rst_n), .rxd(rxd0), .rx_if(if0),
      .frame_err(fe0_w), .parity_err(pe0_w),
      .overrun(ov0_w), .busy(busy0)
   );

   uart_rx_deframer #(
      .CLKS_PER_BIT(CPB), .PARITY(1), .FIFO_DEPTH_LOG2(2)
   ) u1 (
      .clk(clk), .rst_n(rst_n), .rxd(rxd1), .rx_if(if1),
      .frame_err(fe1_w), .parity_err(pe1_w),
      .overrun(ov1_w), .busy(busy1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         line;
      logic [7:0] d;
      int         par;
      logic       stopb;
      logic       acc;
      int         fe;
      int         pe;
   } vec_t;

   vec_t       vecs [10];
   logic [7:0] q0 [$];
   logic [7:0] q1 [$];
   int checks = 0;
   int passed = 0;
   int fe0n = 0, pe0n = 0, ov0n = 0;
   int fe1n = 0, pe1n = 0, ov1n = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
                    nm, act, act, exp, exp);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (if0.rx_valid && if0.rx_ready) begin
            if (q0.size() == 0) begin
               checks++;
               $display("FAIL dut0_unexpected: got 0x%0h want none",
                        if0.rx_data);
            end else begin
               chk("dut0_data", int'(if0.rx_data), int'(q0.pop_front()));
            end
         end
         fe0n += int'(fe0_w);
         pe0n += int'(pe0_w);
         ov0n += int'(ov0_w);
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (if1.rx_valid && if1.rx_ready) begin
            if (q1.size() == 0) begin
               checks++;
               $display("FAIL dut1_unexpected: got 0x%0h want none",
                        if1.rx_data);
            end else begin
               chk("dut1_data", int'(if1.rx_data), int'(q1.pop_front()));
            end
         end
         fe1n += int'(fe1_w);
         pe1n += int'(pe1_w);
         ov1n += int'(ov1_w);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic setl(input int ln, input logic v);
      if (ln == 0) rxd0 = v;
      else rxd1 = v;
   endtask

   task automatic send(input int ln, input logic [7:0] d,
                       input int par, input logic stopb);
      setl(ln, 1'b0);
      tick(CPB);
      for (int b = 0; b < 8; b++) begin
         setl(ln, d[b]);
         tick(CPB);
      end
      if (par >= 0) begin
         setl(ln, par[0]);
         tick(CPB);
      end
      setl(ln, stopb);
      tick(CPB);
   endtask

   task automatic idle(input int ln, input int n);
      setl(ln, 1'b1);
      tick(n);
   endtask

   int b_fe, b_pe, b_ov, ln;

   initial begin
      vecs[0] = '{0, 8'h5A, -1, 1'b1, 1'b1, 0, 0};
      vecs[1] = '{0, 8'h00, -1, 1'b1, 1'b1, 0, 0};
      vecs[2] = '{0, 8'hFF, -1, 1'b1, 1'b1, 0, 0};
      vecs[3] = '{1, 8'h07,  0, 1'b1, 1'b0, 0, 1};
      vecs[4] = '{1, 8'h07,  1, 1'b1, 1'b1, 0, 0};
      vecs[5] = '{1, 8'h80,  1, 1'b1, 1'b1, 0, 0};
      vecs[6] = '{1, 8'hC3,  0, 1'b1, 1'b1, 0, 0};
      vecs[7] = '{1, 8'h0F,  1, 1'b1, 1'b0, 0, 1};
      vecs[8] = '{1, 8'h07,  0, 1'b0, 1'b0, 1, 0};
      vecs[9] = '{0, 8'h81, -1, 1'b0, 1'b0, 1, 0};

      rst_n = 1'b0;
      rxd0 = 1'b1;
      rxd1 = 1'b1;
      if0.rx_ready = 1'b1;
      if1.rx_ready = 1'b1;
      tick(3);
      chk("rst_valid0", int'(if0.rx_valid), 0);
      chk("rst_data0", int'(if0.rx_data), 0);
      chk("rst_busy0", int'(busy0), 0);
      chk("rst_errs0", int'({fe0_w, pe0_w, ov0_w}), 0);
      chk("rst_valid1", int'(if1.rx_valid), 0);
      rst_n = 1'b1;
      tick(4);

      // Exact push latency relative to the stop-bit sample edge.
      q0.push_back(8'hA5);
      fork
         send(0, 8'hA5, -1, 1'b1);
         begin
            tick(78);
            chk("lat_pre", int'(if0.rx_valid), 0);
            tick(1);
            chk("lat_valid", int'(if0.rx_valid), 1);
            chk("lat_data", int'(if0.rx_data), 8'hA5);
            tick(1);
            chk("lat_popped", int'(if0.rx_valid), 0);
            chk("lat_hold", int'(if0.rx_data), 8'hA5);
         end
      join
      idle(0, 8);
      chk("a5_fe", fe0n, 0);
      chk("a5_pe", pe0n, 0);

      // Start-bit glitch shorter than half a bit.
      setl(0, 1'b0);
      tick(3);
      setl(0, 1'b1);
      chk("glitch_busy", int'(busy0), 1);
      tick(12);
      chk("glitch_idle", int'(busy0), 0);
      chk("glitch_fe", fe0n, 0);
      q0.push_back(8'h3C);
      send(0, 8'h3C, -1, 1'b1);
      idle(0, 8);
      chk("glitch_drain", q0.size(), 0);

      // Low stop bit followed by a held-low line.
      b_fe = fe0n;
      send(0, 8'h55, -1, 1'b0);
      tick(40);
      chk("brk_busy", int'(busy0), 1);
      chk("brk_fe", fe0n - b_fe, 1);
      idle(0, 12);
      chk("brk_idle", int'(busy0), 0);
      chk("brk_fe_once", fe0n - b_fe, 1);
      q0.push_back(8'h12);
      send(0, 8'h12, -1, 1'b1);
      idle(0, 8);
      chk("brk_drain", q0.size(), 0);

      for (int i = 0; i < 10; i++) begin
         ln   = vecs[i].line;
         b_fe = (ln == 0) ? fe0n : fe1n;
         b_pe = (ln == 0) ? pe0n : pe1n;
         if (vecs[i].acc) begin
            if (ln == 0) q0.push_back(vecs[i].d);
            else q1.push_back(vecs[i].d);
         end
         send(ln, vecs[i].d, vecs[i].par, vecs[i].stopb);
         idle(ln, 12);
         chk($sformatf("v%0d_fe", i),
             ((ln == 0) ? fe0n : fe1n) - b_fe, vecs[i].fe);
         chk($sformatf("v%0d_pe", i),
             ((ln == 0) ? pe0n : pe1n) - b_pe, vecs[i].pe);
         chk($sformatf("v%0d_drain", i),
             (ln == 0) ? q0.size() : q1.size(), 0);
      end

      // Fill the FIFO, overrun on the fifth byte, then drain.
      if0.rx_ready = 1'b0;
      b_ov = ov0n;
      for (int k = 1; k <= 5; k++) begin
         if (k < 5) q0.push_back(8'(k));
         send(0, 8'(k), -1, 1'b1);
      end
      idle(0, 8);
      chk("ovr_pulse", ov0n - b_ov, 1);
      chk("ovr_valid", int'(if0.rx_valid), 1);
      chk("ovr_head", int'(if0.rx_data), 8'h01);
      if0.rx_ready = 1'b1;
      tick(4);
      if0.rx_ready = 1'b0;
      chk("ovr_empty", int'(if0.rx_valid), 0);
      chk("ovr_drain", q0.size(), 0);

      // Full FIFO with a pop in the stop-sample cycle.
      for (int k = 1; k <= 5; k++) q0.push_back(8'(k));
      for (int k = 1; k <= 4; k++) send(0, 8'(k), -1, 1'b1);
      idle(0, 8);
      b_ov = ov0n;
      fork
         send(0, 8'h05, -1, 1'b1);
         begin
            tick(78);
            if0.rx_ready = 1'b1;
            tick(1);
            if0.rx_ready = 1'b0;
         end
      join
      idle(0, 8);
      chk("pp_no_ovr", ov0n - b_ov, 0);
      chk("pp_valid", int'(if0.rx_valid), 1);
      chk("pp_head", int'(if0.rx_data), 8'h02);
      chk("pp_left", q0.size(), 4);
      if0.rx_ready = 1'b1;
      tick(4);
      if0.rx_ready = 1'b0;
      chk("pp_empty", int'(if0.rx_valid), 0);
      chk("pp_drain", q0.size(), 0);

      // Reset mid-frame with a byte waiting in the FIFO.
      q0.push_back(8'h6B);
      send(0, 8'h6B, -1, 1'b1);
      idle(0, 8);
      chk("mid_valid_pre", int'(if0.rx_valid), 1);
      fork
         send(0, 8'h77, -1, 1'b1);
         begin
            tick(30);
            chk("mid_busy_pre", int'(busy0), 1);
            rst_n = 1'b0;
            #2;
            chk("mid_valid", int'(if0.rx_valid), 0);
            chk("mid_data", int'(if0.rx_data), 0);
            chk("mid_busy", int'(busy0), 0);
            chk("mid_errs", int'({fe0_w, pe0_w, ov0_w}), 0);
            q0.delete();
         end
      join
      idle(0, 4);
      rst_n = 1'b1;
      tick(2);
      if0.rx_ready = 1'b1;
      q0.push_back(8'h9E);
      send(0, 8'h9E, -1, 1'b1);
      idle(0, 8);
      chk("post_rst_drain", q0.size(), 0);
      chk("final_q1", q1.size(), 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
- Asynchronous serial receiver for the auxiliary UART input (io_uart_rxd / io_tp2), 8-N-1 or 8-E/O-1.
- Counterpart of the core's UART transmit path on io_uart_txd.
- Recovers bytes, checks framing and parity, and buffers bytes in a small FIFO with a valid/ready interface to control logic in the clk domain.
- Runs on the single core clock; rxd is fully asynchronous to it.

Parameters:
- CLKS_PER_BIT, 667, clk cycles per bit; 76.8 MHz / 115200. Legal range 4..65535.
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- FIFO_DEPTH_LOG2, 2, FIFO holds 2^N bytes (default 4).

Ports:
- clk  in  1  core clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rxd  in  1  serial line, idle high, asynchronous.
- rx_data  out  8  byte at FIFO head.
- rx_valid  out  1  FIFO not empty.
- rx_ready  in  1  consumer accepts rx_data when rx_valid && rx_ready.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- parity_err  out  1  one-cycle pulse: parity mismatch.
- overrun  out  1  one-cycle pulse: byte dropped because FIFO full.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - Both synchronizer flops = 1; state = IDLE; counters = 0; FIFO empty.
  - rx_data = 0, rx_valid = 0, all error pulses = 0, busy = 0.
- Synchronizer: 2 flops; rxs = second flop. Line-to-rxs latency is 2 cycles.
- Bit counter: counts 0..CLKS_PER_BIT-1 and wraps; it is reset on every state entry.
- IDLE: rxs == 0 -> START.
- START: at count == CLKS_PER_BIT/2 - 1 (integer division), sample rxs.
  - 0: go to DATA, bit index = 0.
  - 1: glitch; return to IDLE with no error.
- DATA: at each count == CLKS_PER_BIT-1, shift rxs in LSB-first.
  - After bit 7: go to PAR if PARITY != 0, else STOP.
- PAR: at count == CLKS_PER_BIT-1, compare rxs with the expected bit.
  - Expected = XOR of data for even, its inverse for odd.
  - Mismatch sets an internal parity-fail flag; go to STOP.
- STOP: at count == CLKS_PER_BIT-1, sample rxs.
  - 1 and no parity fail: push byte; go to IDLE.
  - 1 and parity fail: pulse parity_err; discard byte; go to IDLE.
  - 0: pulse frame_err; discard byte; go to BREAK. frame_err takes precedence over parity_err; only frame_err pulses.
- BREAK: stay until rxs == 1, then go to IDLE. A held-low line yields exactly one frame_err.
- FIFO:
  - Push occurs in the stop-sample cycle; rx_valid/rx_data update on the next cycle. Total latency from the stop-bit sample point is 1 cycle.
  - Pop occurs when rx_valid && rx_ready; the next head appears the following cycle.
  - Push while full without a same-cycle pop: byte dropped, overrun pulses, FIFO contents unchanged.
  - Push and pop in the same cycle while full: both happen; no overrun; count unchanged.
  - Push and pop in the same cycle while empty: not possible, because rx_valid = 0.
  - Read/write pointers are FIFO_DEPTH_LOG2+1 bits wide and wrap naturally.
  - rx_data holds its last value when empty; the consumer must qualify it with rx_valid.
- rx_ready is ignored while rx_valid = 0.
- Reset asserted mid-frame: immediate return to IDLE with FIFO empty. A partial frame in progress at reset release is resynchronised by the low-edge and glitch rules.

Test Plan:
1. CLKS_PER_BIT=8, PARITY=0, rx_ready=1; send 0xA5 as 8-N-1 -> rx_valid high for 1 cycle, 1 cycle after the stop sample, rx_data=0xA5, no error pulses.
2. Low pulse on rxd of 3 clk (shorter than the half-bit of 4) -> returns to IDLE, busy falls, no rx_valid, no errors; a following 0x3C is received correctly.
3. Send 0x55 with stop bit forced low, then hold rxd low for 40 cycles -> exactly one frame_err pulse, no push, busy stays high until rxd returns high; a following 0x12 is received.
4. PARITY=1: send 0x07 with parity bit 0 (wrong; expected 1) -> one parity_err pulse, nothing pushed; send 0x07 with parity 1 -> rx_data=0x07.
5. rx_ready=0; send 0x01..0x05 back-to-back -> after the 4th byte rx_valid=1 with head=0x01; the 5th byte pulses overrun; then raise rx_ready for 4 cycles -> pops 0x01,0x02,0x03,0x04 in order, then rx_valid=0.
6. FIFO full (4 bytes); raise rx_ready exactly in the 5th byte's stop-sample cycle -> no overrun, 0x01 popped, 0x05 stored at tail; assert rst_n=0 mid-byte -> all outputs return to reset values immediately.
